// File: rtl/config_register_bank_if.sv
// Shared widths/types for the config bus, plus the bus interface that bundles
// the write, read-request/response and stream-configuration channels.

package config_register_bank_pkg;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXIL_DATA_BITS = 32;
    typedef logic [3:0] type_t;
endpackage

interface config_register_bank_if #(
    parameter int NUM_SELECT = 4
);
    import config_register_bank_pkg::*;

    localparam int SEL_W = (NUM_SELECT > 1) ? $clog2(NUM_SELECT) : 1;

    // Write channel: no backpressure.
    logic [AXI_ADDR_BITS-1:0]  wr_addr;
    logic [AXIL_DATA_BITS-1:0] wr_data;
    logic                      wr_valid;

    // Read request / response channel.
    logic [AXI_ADDR_BITS-1:0]  rd_addr;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [AXIL_DATA_BITS-1:0] resp_data;
    logic                      resp_error;
    logic                      resp_valid;
    logic                      resp_ready;

    // Stream configuration towards the datapath.
    logic [SEL_W-1:0]          select_data;
    logic                      select_valid;
    logic                      select_ready;
    type_t                     data_type_data;
    logic                      data_type_valid;
    logic                      data_type_ready;

    modport slave (
        input  wr_addr, wr_data, wr_valid,
        input  rd_addr, rd_valid,
        output rd_ready,
        output resp_data, resp_error, resp_valid,
        input  resp_ready,
        output select_data, select_valid,
        input  select_ready,
        output data_type_data, data_type_valid,
        input  data_type_ready
    );

    modport master (
        output wr_addr, wr_data, wr_valid,
        output rd_addr, rd_valid,
        input  rd_ready,
        input  resp_data, resp_error, resp_valid,
        output resp_ready,
        input  select_data, select_valid,
        output select_ready,
        input  data_type_data, data_type_valid,
        output data_type_ready
    );
endinterface

// File: rtl/config_register_bank.sv
// Config register bank: general R/W registers, a clear-on-read STATUS word at
// index NUM_REGS, and two ready/valid stream-config launchers (select and
// data_type) triggered by writes to designated registers.

module config_register_bank
    import config_register_bank_pkg::*;
#(
    parameter int                       NUM_REGS   = 8,
    parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR  = {AXI_ADDR_BITS{1'b0}},
    parameter int                       NUM_SELECT = 4,
    parameter int                       SELECT_IDX = 0,
    parameter int                       TYPE_IDX   = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    config_register_bank_if.slave bus
);

    localparam int ALIGN_BITS = $clog2(AXIL_DATA_BITS / 8);
    localparam int SEL_W      = (NUM_SELECT > 1) ? $clog2(NUM_SELECT) : 1;
    localparam int TYPE_W     = $bits(type_t);

    typedef logic [AXI_ADDR_BITS-1:0]  addr_t;
    typedef logic [AXIL_DATA_BITS-1:0] data_t;

    // Word index of an address relative to the bank base.
    function automatic addr_t addr_index(input addr_t addr);
        return (addr - BASE_ADDR) >> ALIGN_BITS;
    endfunction

    // Address hits a general register or STATUS and is word aligned.
    function automatic logic addr_ok(input addr_t addr);
        return (addr >= BASE_ADDR) &&
               (addr_index(addr) <= addr_t'(NUM_REGS)) &&
               (addr[ALIGN_BITS-1:0] == {ALIGN_BITS{1'b0}});
    endfunction

    // State
    data_t            regs_q [NUM_REGS];
    data_t            regs_d [NUM_REGS];
    logic [1:0]       status_q, status_d;
    data_t            resp_data_q, resp_data_d;
    logic             resp_error_q, resp_error_d;
    logic             resp_valid_q, resp_valid_d;
    logic [SEL_W-1:0] select_data_q, select_data_d;
    logic             select_valid_q, select_valid_d;
    type_t            type_data_q, type_data_d;
    logic             type_valid_q, type_valid_d;

    // Decoded request information
    addr_t      wr_idx_s;
    addr_t      rd_idx_s;
    logic       wr_gen_s;
    logic       sel_wr_s;
    logic       typ_wr_s;
    logic       rd_ok_s;
    logic       rd_status_s;
    logic       rd_ready_s;
    logic       rd_acc_s;
    data_t      rd_word_s;
    logic [1:0] ovf_set_s;

    // Decode write/read addresses and fetch the addressed read word.
    always_comb begin
        wr_idx_s    = addr_index(bus.wr_addr);
        rd_idx_s    = addr_index(bus.rd_addr);
        wr_gen_s    = bus.wr_valid && addr_ok(bus.wr_addr) &&
                      (wr_idx_s < addr_t'(NUM_REGS));
        sel_wr_s    = wr_gen_s && (wr_idx_s == addr_t'(SELECT_IDX));
        typ_wr_s    = wr_gen_s && (wr_idx_s == addr_t'(TYPE_IDX));
        rd_ok_s     = addr_ok(bus.rd_addr);
        rd_status_s = rd_ok_s && (rd_idx_s == addr_t'(NUM_REGS));
        rd_ready_s  = !resp_valid_q || bus.resp_ready;
        rd_acc_s    = bus.rd_valid && rd_ready_s;
        rd_word_s   = {AXIL_DATA_BITS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_word_s = (rd_idx_s == addr_t'(i)) ? regs_q[i] : rd_word_s;
        end
        rd_word_s = rd_status_s ? {{(AXIL_DATA_BITS-2){1'b0}}, status_q} : rd_word_s;
    end

    // Next state for registers, stream launchers, STATUS and read response.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (wr_gen_s && (wr_idx_s == addr_t'(i))) ? bus.wr_data : regs_q[i];
        end

        ovf_set_s      = 2'b00;
        select_valid_d = select_valid_q;
        select_data_d  = select_data_q;
        type_valid_d   = type_valid_q;
        type_data_d    = type_data_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_error_d   = resp_error_q;

        // A launch is refused only while the previous transfer is stalled.
        if (sel_wr_s) begin
            if (select_valid_q && !bus.select_ready) begin
                ovf_set_s[0] = 1'b1;
            end else begin
                select_valid_d = 1'b1;
                select_data_d  = bus.wr_data[SEL_W-1:0];
            end
        end else if (select_valid_q && bus.select_ready) begin
            select_valid_d = 1'b0;
        end else begin
            select_valid_d = select_valid_q;
        end

        if (typ_wr_s) begin
            if (type_valid_q && !bus.data_type_ready) begin
                ovf_set_s[1] = 1'b1;
            end else begin
                type_valid_d = 1'b1;
                type_data_d  = bus.wr_data[TYPE_W-1:0];
            end
        end else if (type_valid_q && bus.data_type_ready) begin
            type_valid_d = 1'b0;
        end else begin
            type_valid_d = type_valid_q;
        end

        // Clear-on-accept, with a same-cycle set taking priority.
        status_d = ((rd_acc_s && rd_status_s) ? 2'b00 : status_q) | ovf_set_s;

        // Response register holds while the consumer stalls.
        if (rd_acc_s) begin
            resp_valid_d = 1'b1;
            resp_data_d  = rd_ok_s ? rd_word_s : {AXIL_DATA_BITS{1'b0}};
            resp_error_d = !rd_ok_s;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {AXIL_DATA_BITS{1'b0}};
            end
            status_q       <= 2'b00;
            resp_data_q    <= {AXIL_DATA_BITS{1'b0}};
            resp_error_q   <= 1'b0;
            resp_valid_q   <= 1'b0;
            select_data_q  <= {SEL_W{1'b0}};
            select_valid_q <= 1'b0;
            type_data_q    <= {TYPE_W{1'b0}};
            type_valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            status_q       <= status_d;
            resp_data_q    <= resp_data_d;
            resp_error_q   <= resp_error_d;
            resp_valid_q   <= resp_valid_d;
            select_data_q  <= select_data_d;
            select_valid_q <= select_valid_d;
            type_data_q    <= type_data_d;
            type_valid_q   <= type_valid_d;
        end
    end

    assign bus.rd_ready        = rd_ready_s;
    assign bus.resp_data       = resp_data_q;
    assign bus.resp_error      = resp_error_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.select_data     = select_data_q;
    assign bus.select_valid    = select_valid_q;
    assign bus.data_type_data  = type_data_q;
    assign bus.data_type_valid = type_valid_q;

endmodule

// File: tb/tb_config_register_bank.sv
// Bench for config_register_bank: directed scenarios followed by a random
// phase, all compared against a behavioural model of the register bank.

module tb_config_register_bank;
    import config_register_bank_pkg::*;

    localparam int          NUM_REGS   = 8;
    localparam logic [31:0] BASE       = 32'h0000_0100;
    localparam int          SELECT_IDX = 0;
    localparam int          TYPE_IDX   = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    config_register_bank_if #(.NUM_SELECT(4)) bus ();

    config_register_bank #(
        .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .NUM_SELECT(4),
        .SELECT_IDX(SELECT_IDX), .TYPE_IDX(TYPE_IDX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model
    logic [31:0] m_regs [NUM_REGS];
    logic [1:0]  m_status;
    bit          m_sel_v;
    logic [1:0]  m_sel_d;
    bit          m_typ_v;
    logic [3:0]  m_typ_d;
    bit          m_rv;
    logic [31:0] m_rdata;
    bit          m_rerr;
    logic [31:0] saved [NUM_REGS];

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        logic [31:0] idx;
        if (a < BASE || (a % 32'd4) != 32'd0) return -1;
        idx = (a - BASE) / 32'd4;
        if (idx > 32'(NUM_REGS)) return -1;
        return int'(idx);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 11));
        if (r <= NUM_REGS) return BASE + 32'(4 * r);
        if (r == 9)  return BASE + 32'(4 * (NUM_REGS + 1));
        if (r == 10) return BASE + 32'd1 + 32'(4 * $urandom_range(0, 7));
        return BASE - 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'd0;
        m_status = 2'b00; m_sel_v = 1'b0; m_sel_d = 2'd0;
        m_typ_v = 1'b0; m_typ_d = 4'd0; m_rv = 1'b0; m_rdata = 32'd0; m_rerr = 1'b0;
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0; bus.wr_addr = BASE; bus.wr_data = 32'd0;
        bus.rd_valid = 1'b0; bus.rd_addr = BASE; bus.resp_ready = 1'b1;
        bus.select_ready = 1'b0; bus.data_type_ready = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs presented now.
    task automatic tick();
        int wi, ri;
        logic [1:0] sets;
        bit acc;
        wi = bus.wr_valid ? decode(bus.wr_addr) : -1;
        ri = decode(bus.rd_addr);
        acc = bus.rd_valid && (!m_rv || bus.resp_ready);
        sets = 2'b00;
        if (wi == SELECT_IDX) begin
            if (m_sel_v && !bus.select_ready) sets[0] = 1'b1;
            else begin m_sel_v = 1'b1; m_sel_d = bus.wr_data[1:0]; end
        end else if (m_sel_v && bus.select_ready) m_sel_v = 1'b0;
        if (wi == TYPE_IDX) begin
            if (m_typ_v && !bus.data_type_ready) sets[1] = 1'b1;
            else begin m_typ_v = 1'b1; m_typ_d = bus.wr_data[3:0]; end
        end else if (m_typ_v && bus.data_type_ready) m_typ_v = 1'b0;
        if (acc) begin
            m_rv = 1'b1;
            if (ri < 0) begin
                m_rdata = 32'd0; m_rerr = 1'b1;
            end else if (ri == NUM_REGS) begin
                m_rdata = {30'd0, m_status}; m_rerr = 1'b0; m_status = 2'b00;
            end else begin
                m_rdata = m_regs[ri]; m_rerr = 1'b0;
            end
        end else if (bus.resp_ready) m_rv = 1'b0;
        m_status = m_status | sets;
        if (wi >= 0 && wi < NUM_REGS) m_regs[wi] = bus.wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        chk_bit("rd_ready", bus.rd_ready, !m_rv || bus.resp_ready);
        chk_bit("resp_valid", bus.resp_valid, m_rv);
        if (m_rv) begin
            chk_word("resp_data", bus.resp_data, m_rdata);
            chk_bit("resp_error", bus.resp_error, m_rerr);
        end
        chk_bit("select_valid", bus.select_valid, m_sel_v);
        if (m_sel_v) chk_word("select_data", 32'(bus.select_data), 32'(m_sel_d));
        chk_bit("type_valid", bus.data_type_valid, m_typ_v);
        if (m_typ_v) chk_word("type_data", 32'(bus.data_type_data), 32'(m_typ_d));
    endtask

    task automatic cycle();
        tick();
        check_all();
    endtask

    task automatic wr(input int idx_words, input logic [31:0] data);
        bus.wr_valid = 1'b1; bus.wr_addr = BASE + 32'(4 * idx_words); bus.wr_data = data;
        cycle();
        bus.wr_valid = 1'b0;
    endtask

    task automatic rd_addr_cycle(input logic [31:0] addr);
        bus.rd_valid = 1'b1; bus.rd_addr = addr;
        cycle();
        bus.rd_valid = 1'b0;
    endtask

    task automatic sweep();
        for (int i = 0; i <= NUM_REGS; i++) rd_addr_cycle(BASE + 32'(4 * i));
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_resp_valid", bus.resp_valid, 1'b0);
        chk_bit("reset_select_valid", bus.select_valid, 1'b0);
        chk_bit("reset_type_valid", bus.data_type_valid, 1'b0);
        chk_bit("reset_rd_ready", bus.rd_ready, 1'b1);
        rst_n = 1'b1;
        check_all();

        // Write then read back register 3.
        wr(3, 32'hDEAD_BEEF);
        rd_addr_cycle(BASE + 32'd12);
        chk_bit("tp1_valid", bus.resp_valid, 1'b1);
        chk_word("tp1_data", bus.resp_data, 32'hDEAD_BEEF);
        chk_bit("tp1_error", bus.resp_error, 1'b0);
        cycle();

        // Invalid addresses: beyond STATUS, misaligned, below base.
        rd_addr_cycle(BASE + 32'(4 * (NUM_REGS + 1)));
        chk_bit("oor_error", bus.resp_error, 1'b1);
        chk_word("oor_data", bus.resp_data, 32'd0);
        rd_addr_cycle(BASE + 32'd1);
        chk_bit("misalign_error", bus.resp_error, 1'b1);
        chk_word("misalign_data", bus.resp_data, 32'd0);
        rd_addr_cycle(BASE - 32'd4);
        chk_bit("below_error", bus.resp_error, 1'b1);
        bus.wr_valid = 1'b1; bus.wr_data = $urandom;
        bus.wr_addr = BASE + 32'(4 * (NUM_REGS + 1)); cycle();
        bus.wr_addr = BASE + 32'd1; cycle();
        bus.wr_addr = BASE + 32'(4 * NUM_REGS); cycle();
        bus.wr_valid = 1'b0;
        sweep();
        rd_addr_cycle(BASE + 32'd12);
        chk_word("reg3_kept", bus.resp_data, 32'hDEAD_BEEF);

        // Select launch, stall, overflow and handshake.
        wr(SELECT_IDX, 32'd2);
        for (int i = 0; i < 2; i++) begin
            chk_bit("sel_hold_valid", bus.select_valid, 1'b1);
            chk_word("sel_hold_data", 32'(bus.select_data), 32'd2);
            cycle();
        end
        wr(SELECT_IDX, 32'd3);
        chk_word("sel_ovf_data", 32'(bus.select_data), 32'd2);
        rd_addr_cycle(BASE + 32'(4 * NUM_REGS));
        chk_word("status_set", bus.resp_data, 32'h1);
        rd_addr_cycle(BASE + 32'(4 * NUM_REGS));
        chk_word("status_cleared", bus.resp_data, 32'h0);
        rd_addr_cycle(BASE + 32'(4 * SELECT_IDX));
        chk_word("sel_reg_updated", bus.resp_data, 32'd3);
        chk_word("sel_still_2", 32'(bus.select_data), 32'd2);
        bus.select_ready = 1'b1;
        wr(SELECT_IDX, 32'd1);
        chk_bit("sel_relaunch_valid", bus.select_valid, 1'b1);
        chk_word("sel_relaunch_data", 32'(bus.select_data), 32'd1);
        cycle();
        chk_bit("sel_done", bus.select_valid, 1'b0);
        bus.select_ready = 1'b0;

        // Data-type launch with overflow.
        wr(TYPE_IDX, 32'h5);
        wr(TYPE_IDX, 32'h6);
        chk_word("type_kept", 32'(bus.data_type_data), 32'h5);
        rd_addr_cycle(BASE + 32'(4 * NUM_REGS));
        chk_word("status_type_ovf", bus.resp_data, 32'h2);
        bus.data_type_ready = 1'b1;
        cycle();
        chk_bit("type_done", bus.data_type_valid, 1'b0);
        bus.data_type_ready = 1'b0;

        // Response backpressure.
        for (int i = 2; i <= 5; i++) begin
            saved[i] = $urandom;
            wr(i, saved[i]);
        end
        bus.resp_ready = 1'b0; bus.rd_valid = 1'b1;
        bus.rd_addr = BASE + 32'd8;
        cycle();
        bus.rd_addr = BASE + 32'd12;
        for (int i = 0; i < 3; i++) begin
            chk_bit("bp_rd_ready", bus.rd_ready, 1'b0);
            chk_word("bp_data_stable", bus.resp_data, saved[2]);
            cycle();
        end
        bus.resp_ready = 1'b1;
        for (int i = 3; i <= 5; i++) begin
            bus.rd_addr = BASE + 32'(4 * i);
            cycle();
            chk_word("bp_drain", bus.resp_data, saved[i]);
        end
        bus.rd_valid = 1'b0;
        cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_addr = rand_addr();
            bus.wr_data = $urandom;
            bus.rd_valid = 1'($urandom_range(0, 1));
            bus.rd_addr = rand_addr();
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.select_ready = 1'($urandom_range(0, 1));
            bus.data_type_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        cycle();

        // Asynchronous reset with transfers pending.
        wr(SELECT_IDX, 32'd2);
        bus.resp_ready = 1'b0;
        rd_addr_cycle(BASE);
        chk_bit("pre_rst_sel", bus.select_valid, 1'b1);
        chk_bit("pre_rst_resp", bus.resp_valid, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_bit("async_sel_drop", bus.select_valid, 1'b0);
        chk_bit("async_resp_drop", bus.resp_valid, 1'b0);
        chk_bit("async_rd_ready", bus.rd_ready, 1'b1);
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep();
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr_cycle(BASE + 32'(4 * i));
            chk_word("post_rst_zero", bus.resp_data, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
